dadda_mult_3_2: RTL and testbench



---
 rtl/dadda_mult_3_2.sv | 153 +++++++++++++++
 tb/tb_dadda_mult_3_2.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mult_3_2.sv
// ---------------------------------------------------------------------------
// dadda_mult_3_2
//   Registered unsigned 4x4 -> 8 multiplier. The partial products go through
//   a Dadda reduction tree of full adders (3:2 counters) and half adders
//   (2:2 counters). A ripple-carry adder built from the same cells then sums
//   the two remaining rows. A valid flag travels alongside the data.
//
//   Ports:
//     clk       in   1  rising-edge clock
//     rst_n     in   1  synchronous active-low reset
//     in_valid  in   1  a/b hold an operand pair this cycle
//     a         in   4  multiplicand, unsigned
//     b         in   4  multiplier, unsigned
//     product   out  8  a*b, exact
//     out_valid out  1  product belongs to a valid operand pair
//
//   Build option:
//     DADDA_INPUT_REG_EN  adds an input register stage on a, b and in_valid.
//                         Latency goes from 1 to 2 cycles; throughput and
//                         results are unchanged.
// ---------------------------------------------------------------------------

// 3:2 counter
module dadda_fa (
    input  logic i_x,
    input  logic i_y,
    input  logic i_z,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y ^ i_z;
    assign o_c = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);
endmodule

// 2:2 counter
module dadda_ha (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module dadda_mult_3_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product,
    output logic       out_valid
);
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic       w_vld;

`ifdef DADDA_INPUT_REG_EN
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_a   <= a;
            r_b   <= b;
            r_vld <= in_valid;
        end
    end

    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_vld = r_vld;
`else
    assign w_a   = a;
    assign w_b   = b;
    assign w_vld = in_valid;
`endif

    // w_pp[i][j] = a[i] & b[j], weight 2^(i+j)
    logic [3:0][3:0] w_pp;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ppi
            for (genvar gj = 0; gj < 4; gj++) begin : g_ppj
                assign w_pp[gi][gj] = w_a[gi] & w_b[gj];
            end
        end
    endgenerate

    // Stage 1 brings every column down to height 3. Columns 3 and 4 each lose
    // one bit through a half adder. The carry from column 4 raises column 5 to 3.
    logic w_s1_3, w_c1_3, w_s1_4, w_c1_4;

    dadda_ha u_s1_c3 (.i_x(w_pp[3][0]), .i_y(w_pp[2][1]), .o_s(w_s1_3), .o_c(w_c1_3));
    dadda_ha u_s1_c4 (.i_x(w_pp[3][1]), .i_y(w_pp[2][2]), .o_s(w_s1_4), .o_c(w_c1_4));

    // Stage 2 brings every column down to height 2. Each carry lands in the
    // next column, so columns 3..5 need a full adder to absorb it.
    logic w_s2_2, w_c2_2, w_s2_3, w_c2_3, w_s2_4, w_c2_4, w_s2_5, w_c2_5;

    dadda_ha u_s2_c2 (.i_x(w_pp[2][0]), .i_y(w_pp[1][1]),
                      .o_s(w_s2_2), .o_c(w_c2_2));
    dadda_fa u_s2_c3 (.i_x(w_s1_3), .i_y(w_pp[1][2]), .i_z(w_pp[0][3]),
                      .o_s(w_s2_3), .o_c(w_c2_3));
    dadda_fa u_s2_c4 (.i_x(w_s1_4), .i_y(w_pp[1][3]), .i_z(w_c1_3),
                      .o_s(w_s2_4), .o_c(w_c2_4));
    dadda_fa u_s2_c5 (.i_x(w_pp[3][2]), .i_y(w_pp[2][3]), .i_z(w_c1_4),
                      .o_s(w_s2_5), .o_c(w_c2_5));

    // The two remaining rows cover columns 1..6. Column 0 is a single bit.
    logic [6:1] w_row0;
    logic [6:1] w_row1;
    logic [6:1] w_sum;
    logic [7:2] w_cy;     // w_cy[k] = carry into column k

    assign w_row0 = {w_pp[3][3], w_s2_5, w_s2_4, w_s2_3, w_s2_2, w_pp[1][0]};
    assign w_row1 = {w_c2_5,     w_c2_4, w_c2_3, w_c2_2, w_pp[0][2], w_pp[0][1]};

    dadda_ha u_cpa_c1 (.i_x(w_row0[1]), .i_y(w_row1[1]), .o_s(w_sum[1]), .o_c(w_cy[2]));

    generate
        for (genvar gk = 2; gk <= 6; gk++) begin : g_cpa
            dadda_fa u_fa (.i_x(w_row0[gk]), .i_y(w_row1[gk]), .i_z(w_cy[gk]),
                           .o_s(w_sum[gk]), .o_c(w_cy[gk+1]));
        end
    endgenerate

    logic [7:0] w_prod;
    assign w_prod = {w_cy[7], w_sum, w_pp[0][0]};

    logic [7:0] r_product;
    logic       r_out_valid;

    // product is loaded every cycle. in_valid only qualifies it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_product   <= w_prod;
            r_out_valid <= w_vld;
        end
    end

    assign product   = r_product;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_dadda_mult_3_2.sv
module tb_dadda_mult_3_2;
`ifdef DADDA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [7:0] product;
    logic       out_valid;

    int checks = 0;
    int failures = 0;

    // Reference: a delay line of ideal products and valid flags, LAT deep.
    // Slot LAT-1 holds the value the DUT output should show after the edge.
    logic [7:0] mp [LAT];
    logic       mv [LAT];

    dadda_mult_3_2 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .product(product), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Apply the current inputs at the next edge, advance the model, and
    // return 1 time unit after the edge so outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                mp[k] = 8'h00;
                mv[k] = 1'b0;
            end
        end else begin
            for (int k = LAT - 1; k > 0; k--) begin
                mp[k] = mp[k-1];
                mv[k] = mv[k-1];
            end
            mp[0] = {4'b0, a} * {4'b0, b};
            mv[0] = in_valid;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'hF;
        for (int t = 0; t < 2; t++) begin
            tick();
            checks++;
            if (product !== 8'h00 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset: product=%h valid=%b, want 00/0", product, out_valid);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; a = i[7:4]; b = i[3:0];
            tick();
            checks++;
            if (product !== mp[LAT-1] || out_valid !== mv[LAT-1]) begin
                failures++;
                $display("FAIL sweep[%0d]: product=%h valid=%b, want %h/%b",
                         i, product, out_valid, mp[LAT-1], mv[LAT-1]);
            end
        end
        // The last LAT-1 results are still in the pipeline; let them drain.
        in_valid = 1'b0;
        for (int t = 0; t < LAT - 1; t++) begin
            tick();
            checks++;
            if (product !== mp[LAT-1] || out_valid !== mv[LAT-1]) begin
                failures++;
                $display("FAIL sweep_drain: product=%h valid=%b, want %h/%b",
                         product, out_valid, mp[LAT-1], mv[LAT-1]);
            end
        end
    endtask

    task automatic test_corners();
        logic [3:0] ta [6] = '{4'h1, 4'h0, 4'h8, 4'h3, 4'hF, 4'h0};
        logic [3:0] tb [6] = '{4'hB, 4'hF, 4'h8, 4'h5, 4'hF, 4'hF};
        logic [7:0] te [6] = '{8'h0B, 8'h00, 8'h40, 8'h0F, 8'hE1, 8'h00};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = ta[i]; b = tb[i];
            for (int t = 0; t < LAT; t++) tick();
            checks++;
            if (product !== te[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL corner %0dx%0d: product=%h valid=%b, want %h/1",
                         ta[i], tb[i], product, out_valid, te[i]);
            end
        end
    endtask

    task automatic test_valid_gating();
        logic [3:0] ga [5] = '{4'd2, 4'd7, 4'd4, 4'd0, 4'd0};
        logic [3:0] gb [5] = '{4'd3, 4'd7, 4'd4, 4'd0, 4'd0};
        logic       gv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 5; t++) begin
            in_valid = gv[t]; a = ga[t]; b = gb[t];
            tick();
            if (t == LAT - 1) begin
                checks++;
                if (product !== 8'h06 || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL gating slot0: product=%h valid=%b, want 06/1", product, out_valid);
                end
            end
            if (t == LAT) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL gating slot1: valid=%b, want 0", out_valid);
                end
            end
            if (t == LAT + 1) begin
                checks++;
                if (product !== 8'h10 || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL gating slot2: product=%h valid=%b, want 10/1", product, out_valid);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 20; t++) begin
            in_valid = 1'b1;
            a = t[0] ? 4'h0 : 4'hF;
            b = a;
            tick();
            if (t >= LAT - 1) begin
                checks++;
                // Output now reflects the input from tick t-LAT+1.
                if (product !== (((t - LAT + 1) % 2 == 0) ? 8'hE1 : 8'h00) || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b[%0d]: product=%h valid=%b", t, product, out_valid);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; a = 4'hF; b = 4'hF;
        for (int t = 0; t < 3; t++) tick();
        rst_n = 1'b0;  // in_valid stays high: reset must win
        tick();
        checks++;
        if (product !== 8'h00 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset: product=%h valid=%b, want 00/0", product, out_valid);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        for (int t = 0; t < LAT + 1; t++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL postreset_flush[%0d]: valid=%b, want 0", t, out_valid);
            end
        end
        in_valid = 1'b1; a = 4'd6; b = 4'd9;
        for (int t = 0; t < LAT; t++) tick();
        checks++;
        if (product !== 8'h36 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL postreset_first: product=%h valid=%b, want 36/1", product, out_valid);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            rst_n    = ($urandom_range(0, 31) != 0);
            in_valid = $urandom_range(0, 1);
            a        = 4'($urandom);
            b        = 4'($urandom);
            tick();
            checks++;
            if (product !== mp[LAT-1] || out_valid !== mv[LAT-1]) begin
                failures++;
                $display("FAIL random[%0d]: product=%h valid=%b, want %h/%b",
                         t, product, out_valid, mp[LAT-1], mv[LAT-1]);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < LAT; k++) begin
            mp[k] = 8'h00;
            mv[k] = 1'b0;
        end
        test_reset();
        test_sweep();
        test_corners();
        test_valid_gating();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
